// File: rtl/ifetch_if.sv
// Instruction-memory request/acknowledge bus between ifetch and imem.
// The fetch stage drives the request; memory returns ack and data.
interface ifetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: one outstanding imem request, a single-entry
// output register towards decode, and stale-response dropping after flush.
module ifetch #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] pc_addr,
    input  logic        flush,
    input  logic        id_ready,
    ifetch_if.master    imem,
    output logic        pc_stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] req_addr;
    logic        capture;
    logic        transfer;
    logic        release_hold;

    always_comb begin
        state_nx       = state;
        imem.imem_req  = 1'b0;
        imem.imem_addr = req_addr;
        pc_stall       = 1'b1;
        capture        = 1'b0;
        transfer       = 1'b0;
        release_hold   = 1'b0;
        unique case (state)
            FETCH: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = pc_addr;
                if (imem.imem_ack && !flush) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end else if (!imem.imem_ack && flush) begin
                    state_nx = DROP;
                end
            end
            HOLD: begin
                pc_stall = !id_ready;
                if (flush) begin
                    release_hold = 1'b1;
                    state_nx     = FETCH;
                end else if (id_ready) begin
                    release_hold = 1'b1;
                    transfer     = 1'b1;
                    state_nx     = FETCH;
                end
            end
            DROP: begin
                // The stale request must complete before a new one issues.
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    state_nx = FETCH;
                end
            end
            default: begin
                state_nx = FETCH;
            end
        endcase
        if (flush) begin
            pc_stall = 1'b0;
        end
        if (rest) begin
            imem.imem_req = 1'b0;
            pc_stall      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state     <= FETCH;
            if_valid  <= 1'b0;
            if_instr  <= RESET_INSTR;
            if_pc     <= 32'h0;
            req_addr  <= 32'h0;
            fetch_cnt <= 32'h0;
        end else begin
            state <= state_nx;
            if (state == FETCH) begin
                req_addr <= pc_addr;
            end
            if (capture) begin
                if_instr <= imem.imem_rdata;
                if_pc    <= pc_addr;
                if_valid <= 1'b1;
            end
            if (release_hold) begin
                if_valid <= 1'b0;
            end
            if (transfer) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    assign if_pc4 = if_pc + 32'd4;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: pc-stage and latency-programmable imem models,
// scoreboard of expected decode transfers plus directed cycle checks.
module tb_ifetch;

    localparam logic [31:0] RI  = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] pc_addr;
    logic        flush;
    logic        id_ready;
    logic [31:0] target;
    int          lat;
    int          wcnt;
    int          cyc = 0;
    logic        pc_stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] fetch_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   tcyc[$];

    ifetch_if bus ();

    ifetch #(.RESET_INSTR(RI)) dut (
        .clk       (clk),
        .rest      (rest),
        .pc_addr   (pc_addr),
        .flush     (flush),
        .id_ready  (id_ready),
        .imem      (bus.master),
        .pc_stall  (pc_stall),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .if_pc4    (if_pc4),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // pc stage model
    always @(posedge clk) begin
        if (rest)
            pc_addr <= 32'h0;
        else if (flush)
            pc_addr <= target;
        else if (!pc_stall)
            pc_addr <= pc_addr + 32'd4;
    end

    // imem model: ack after lat wait cycles
    assign bus.imem_ack   = bus.imem_req && (wcnt == lat);
    assign bus.imem_rdata = bus.imem_addr ^ KEY;

    always @(posedge clk) begin
        if (rest)
            wcnt <= 0;
        else if (bus.imem_req)
            wcnt <= bus.imem_ack ? 0 : wcnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic push(input logic [31:0] a);
        exp_q.push_back('{pc: a, ins: a ^ KEY});
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        if (!rest && if_valid && id_ready && !flush) begin
            tcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer_unexpected: got pc %h want none",
                         if_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("xfer_pc", if_pc, e.pc);
                chk("xfer_instr", if_instr, e.ins);
                chk("xfer_pc4", if_pc4, e.pc + 32'd4);
            end
        end
    end

    task automatic wait_fetch(input logic [31:0] a);
        bit hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_addr == a) hit = 1;
        end
        chk("wait_fetch", {31'b0, hit}, 32'd1);
    endtask

    task automatic wait_hold(input logic [31:0] a);
        bit hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (if_valid && if_pc == a) hit = 1;
        end
        chk("wait_hold", {31'b0, hit}, 32'd1);
    endtask

    initial begin
        rest     = 1'b1;
        flush    = 1'b0;
        id_ready = 1'b0;
        lat      = 0;
        target   = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_stall", {31'b0, pc_stall}, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, RI);
        chk("rst_cnt", fetch_cnt, 32'd0);

        // zero-wait streaming
        @(posedge clk);
        #1;
        rest     = 1'b0;
        id_ready = 1'b1;
        push(32'h0);
        push(32'h4);
        push(32'h8);
        @(negedge clk);
        chk("first_req", {31'b0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);
        chk("first_stall", {31'b0, pc_stall}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        id_ready = 1'b0;
        @(negedge clk);
        chk("stream_cnt", fetch_cnt, 32'd3);
        chk("stream_n", tcyc.size(), 32'd3);
        if (tcyc.size() >= 3) begin
            chk("space01", tcyc[1] - tcyc[0], 32'd2);
            chk("space12", tcyc[2] - tcyc[1], 32'd2);
        end

        // decode back-pressure in HOLD
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, if_valid}, 32'd1);
            chk("hold_instr", if_instr, 32'h0000_000C ^ KEY);
            chk("hold_stall", {31'b0, pc_stall}, 32'd1);
            chk("hold_req", {31'b0, bus.imem_req}, 32'd0);
            chk("hold_cnt", fetch_cnt, 32'd3);
        end

        // delayed ack at 0x10
        @(posedge clk);
        #1;
        lat      = 3;
        id_ready = 1'b1;
        push(32'hC);
        push(32'h10);
        @(negedge clk);
        repeat (4) begin
            @(negedge clk);
            chk("wait_req", {31'b0, bus.imem_req}, 32'd1);
            chk("wait_addr", bus.imem_addr, 32'h10);
            chk("wait_stall", {31'b0, pc_stall}, 32'd1);
            chk("wait_valid", {31'b0, if_valid}, 32'd0);
        end
        @(negedge clk);
        chk("cap_valid", {31'b0, if_valid}, 32'd1);
        chk("cap_pc", if_pc, 32'h10);
        chk("cap_req", {31'b0, bus.imem_req}, 32'd0);
        push(32'h14);
        push(32'h18);
        push(32'h1C);

        // flush during unacked fetch at 0x20
        wait_fetch(32'h20);
        flush  = 1'b1;
        target = 32'h80;
        #1;
        chk("fl_stall", {31'b0, pc_stall}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("drop_req", {31'b0, bus.imem_req}, 32'd1);
            chk("drop_addr", bus.imem_addr, 32'h20);
            chk("drop_valid", {31'b0, if_valid}, 32'd0);
            chk("drop_stall", {31'b0, pc_stall}, 32'd1);
        end
        @(negedge clk);
        chk("redir_req", {31'b0, bus.imem_req}, 32'd1);
        chk("redir_addr", bus.imem_addr, 32'h80);
        chk("redir_cnt", fetch_cnt, 32'd8);
        lat = 0;
        push(32'h80);

        // flush coincident with ack
        wait_fetch(32'h84);
        flush  = 1'b1;
        target = 32'h100;
        #1;
        chk("flack_stall", {31'b0, pc_stall}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        push(32'h100);
        @(negedge clk);
        chk("flack_valid", {31'b0, if_valid}, 32'd0);
        chk("flack_addr", bus.imem_addr, 32'h100);
        chk("flack_cnt", fetch_cnt, 32'd9);

        // flush wins over id_ready in HOLD
        wait_hold(32'h104);
        flush  = 1'b1;
        target = 32'h200;
        #1;
        chk("flhold_stall", {31'b0, pc_stall}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flhold_valid", {31'b0, if_valid}, 32'd0);
        chk("flhold_addr", bus.imem_addr, 32'h200);
        chk("flhold_cnt", fetch_cnt, 32'd10);
        lat = 2;
        push(32'h200);

        // reset during DROP
        wait_fetch(32'h204);
        flush  = 1'b1;
        target = 32'h300;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("rd_addr", bus.imem_addr, 32'h204);
        chk("rd_req", {31'b0, bus.imem_req}, 32'd1);
        rest = 1'b1;
        #1;
        chk("rd_rreq", {31'b0, bus.imem_req}, 32'd0);
        chk("rd_rstall", {31'b0, pc_stall}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rd_valid", {31'b0, if_valid}, 32'd0);
        chk("rd_instr", if_instr, RI);
        chk("rd_cnt", fetch_cnt, 32'd0);
        chk("rd_req2", {31'b0, bus.imem_req}, 32'd0);
        @(posedge clk);
        #1;
        rest = 1'b0;
        push(32'h0);
        @(negedge clk);
        chk("rel_req", {31'b0, bus.imem_req}, 32'd1);
        chk("rel_addr", bus.imem_addr, 32'h0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            @(negedge clk);
        chk("drain", exp_q.size(), 32'd0);
        chk("end_cnt", fetch_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
